// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard and sequencing controller for a five-stage
//               F/D/E/M/W pipeline. It resolves load-use hazards, branch
//               mispredicts, multi-cycle MUL/DIV occupancy of E, exceptions
//               and halt. Stall and bubble controls are combinational from
//               the state, the MDU down-counter and the inputs.
// Ports       : clk_i, rst_i (async, active-high)
//               d_srcA_i, d_srcB_i   decode source registers
//               E_dstM_i             load destination of the E instruction
//               E_is_load_i, E_mdu_i E instruction class
//               e_mispred_i          branch in E mispredicted
//               m_err_i, W_halt_i    exception in M / halt in W
//               *_stall_o            hold stage register
//               *_bubble_o           load NOP into stage register
//               W_stall_o            block writeback
//               mdu_busy_o, mdu_done_o, halted_o  status
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int REG_WIDTH = 5,
    parameter int MDU_LAT   = 4,
    parameter int RNONE     = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REG_WIDTH-1:0] d_srcA_i,
    input  logic [REG_WIDTH-1:0] d_srcB_i,
    input  logic [REG_WIDTH-1:0] E_dstM_i,
    input  logic                 E_is_load_i,
    input  logic                 E_mdu_i,
    input  logic                 e_mispred_i,
    input  logic                 m_err_i,
    input  logic                 W_halt_i,
    output logic                 F_stall_o,
    output logic                 D_stall_o,
    output logic                 E_stall_o,
    output logic                 D_bubble_o,
    output logic                 E_bubble_o,
    output logic                 M_bubble_o,
    output logic                 W_stall_o,
    output logic                 mdu_busy_o,
    output logic                 mdu_done_o,
    output logic                 halted_o
);

    localparam int c_CNT_W = $clog2(MDU_LAT) + 1;

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MDU_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HALT     = 2'd2;

    localparam logic [REG_WIDTH-1:0] c_RNONE   = REG_WIDTH'(RNONE);
    // The RUN entry cycle counts as the first occupancy cycle and the
    // cnt==0 cycle as the last, so the counter starts two below MDU_LAT.
    localparam logic [c_CNT_W-1:0]   c_CNT_INIT = c_CNT_W'(MDU_LAT - 2);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_next_cnt;

    logic w_load_use;
    logic w_exc;

    logic w_f_stall, w_d_stall, w_e_stall;
    logic w_d_bubble, w_e_bubble, w_m_bubble;
    logic w_w_stall, w_busy, w_done, w_halted;

    assign w_load_use = E_is_load_i && (E_dstM_i != c_RNONE) &&
                        ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign w_exc      = m_err_i || W_halt_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_f_stall    = 1'b0;
        w_d_stall    = 1'b0;
        w_e_stall    = 1'b0;
        w_d_bubble   = 1'b0;
        w_e_bubble   = 1'b0;
        w_m_bubble   = 1'b0;
        w_w_stall    = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_halted     = 1'b0;

        case (r_state)
            c_ST_RUN: begin
                if (w_exc) begin
                    w_m_bubble   = 1'b1;
                    w_w_stall    = W_halt_i;
                    w_next_state = c_ST_HALT;
                end else if (e_mispred_i) begin
                    w_d_bubble = 1'b1;
                    w_e_bubble = 1'b1;
                end else if (E_mdu_i) begin
                    w_f_stall    = 1'b1;
                    w_d_stall    = 1'b1;
                    w_e_stall    = 1'b1;
                    w_m_bubble   = 1'b1;
                    w_next_state = c_ST_MDU_WAIT;
                    w_next_cnt   = c_CNT_INIT;
                end else if (w_load_use) begin
                    w_f_stall  = 1'b1;
                    w_d_stall  = 1'b1;
                    w_e_bubble = 1'b1;
                end
            end

            c_ST_MDU_WAIT: begin
                // Mispredict, new MDU and load-use are deliberately ignored
                // here: the front end is frozen behind the MDU op anyway.
                w_f_stall = 1'b1;
                w_d_stall = 1'b1;
                w_busy    = 1'b1;
                if (w_exc) begin
                    // The MDU result is abandoned, so no done pulse.
                    w_e_stall    = 1'b1;
                    w_m_bubble   = 1'b1;
                    w_w_stall    = W_halt_i;
                    w_next_state = c_ST_HALT;
                    w_next_cnt   = '0;
                end else if (r_cnt == '0) begin
                    // Last cycle: release E so the result advances to M.
                    w_done       = 1'b1;
                    w_next_state = c_ST_RUN;
                end else begin
                    w_e_stall  = 1'b1;
                    w_m_bubble = 1'b1;
                    w_next_cnt = r_cnt - 1'b1;
                end
            end

            c_ST_HALT: begin
                w_f_stall  = 1'b1;
                w_d_stall  = 1'b1;
                w_e_stall  = 1'b1;
                w_m_bubble = 1'b1;
                w_w_stall  = 1'b1;
                w_halted   = 1'b1;
            end

            default: begin
                w_next_state = c_ST_RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Reset forces every output low even though RUN rules would otherwise
    // react to whatever the pipeline presents on the inputs.
    assign F_stall_o  = w_f_stall  & ~rst_i;
    assign D_stall_o  = w_d_stall  & ~rst_i;
    assign E_stall_o  = w_e_stall  & ~rst_i;
    assign D_bubble_o = w_d_bubble & ~rst_i;
    assign E_bubble_o = w_e_bubble & ~rst_i;
    assign M_bubble_o = w_m_bubble & ~rst_i;
    assign W_stall_o  = w_w_stall  & ~rst_i;
    assign mdu_busy_o = w_busy     & ~rst_i;
    assign mdu_done_o = w_done     & ~rst_i;
    assign halted_o   = w_halted   & ~rst_i;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl (default params).
//               Outputs are packed as
//               {F_stall,D_stall,E_stall,D_bubble,E_bubble,M_bubble,
//                W_stall,mdu_busy,mdu_done,halted}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam logic [9:0] c_NONE     = 10'b000_000_0_000;
    localparam logic [9:0] c_LOADUSE  = 10'b110_010_0_000;
    localparam logic [9:0] c_MISPRED  = 10'b000_110_0_000;
    localparam logic [9:0] c_MDU_ENT  = 10'b111_001_0_000;
    localparam logic [9:0] c_MDU_WAIT = 10'b111_001_0_100;
    localparam logic [9:0] c_MDU_DONE = 10'b110_000_0_110;
    localparam logic [9:0] c_RUN_ERR  = 10'b000_001_0_000;
    localparam logic [9:0] c_RUN_HALT = 10'b000_001_1_000;
    localparam logic [9:0] c_HALT     = 10'b111_001_1_001;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] d_srcA_i = '0;
    logic [4:0] d_srcB_i = '0;
    logic [4:0] E_dstM_i = '0;
    logic       E_is_load_i = 1'b0;
    logic       E_mdu_i = 1'b0;
    logic       e_mispred_i = 1'b0;
    logic       m_err_i = 1'b0;
    logic       W_halt_i = 1'b0;
    logic       F_stall_o, D_stall_o, E_stall_o;
    logic       D_bubble_o, E_bubble_o, M_bubble_o;
    logic       W_stall_o, mdu_busy_o, mdu_done_o, halted_o;

    logic [9:0] outs;
    int         n_cmp = 0;
    int         n_fail = 0;

    assign outs = {F_stall_o, D_stall_o, E_stall_o, D_bubble_o, E_bubble_o,
                   M_bubble_o, W_stall_o, mdu_busy_o, mdu_done_o, halted_o};

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.REG_WIDTH(5), .MDU_LAT(4), .RNONE(0)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .d_srcA_i    (d_srcA_i),
        .d_srcB_i    (d_srcB_i),
        .E_dstM_i    (E_dstM_i),
        .E_is_load_i (E_is_load_i),
        .E_mdu_i     (E_mdu_i),
        .e_mispred_i (e_mispred_i),
        .m_err_i     (m_err_i),
        .W_halt_i    (W_halt_i),
        .F_stall_o   (F_stall_o),
        .D_stall_o   (D_stall_o),
        .E_stall_o   (E_stall_o),
        .D_bubble_o  (D_bubble_o),
        .E_bubble_o  (E_bubble_o),
        .M_bubble_o  (M_bubble_o),
        .W_stall_o   (W_stall_o),
        .mdu_busy_o  (mdu_busy_o),
        .mdu_done_o  (mdu_done_o),
        .halted_o    (halted_o)
    );

    // Advance to 1 ns after the next rising edge; inputs change here and
    // outputs are sampled 2 ns later, well clear of either clock edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        d_srcA_i = '0; d_srcB_i = '0; E_dstM_i = '0;
        E_is_load_i = 0; E_mdu_i = 0; e_mispred_i = 0; m_err_i = 0; W_halt_i = 0;
    endtask

    // Asynchronous reset pulse mid-cycle; returns with rst_i low, inputs clear.
    task automatic pulse_reset(input string tag);
        #2;
        rst_i = 1'b1;
        E_mdu_i = 1'b1; m_err_i = 1'b1;
        #1;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++;
            $display("FAIL %s_during_rst: got %b want %b", tag, outs, c_NONE);
        end
        clear_inputs();
        #2;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        E_mdu_i = 1; e_mispred_i = 1; m_err_i = 1; W_halt_i = 1;
        #1;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", outs, c_NONE);
        end
        clear_inputs();
        #2;
        rst_i = 0;
        next_cycle();
        #2;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL reset_idle: got %b want %b", outs, c_NONE);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        E_is_load_i = 1; E_dstM_i = 5; d_srcB_i = 5; d_srcA_i = 3;
        #2;
        n_cmp++;
        if (outs !== c_LOADUSE) begin
            n_fail++; $display("FAIL loaduse_srcB: got %b want %b", outs, c_LOADUSE);
        end
        next_cycle();
        clear_inputs();
        #2;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL loaduse_one_cycle: got %b want %b", outs, c_NONE);
        end
        next_cycle();
        E_is_load_i = 1; E_dstM_i = 0; d_srcA_i = 0;
        #2;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL loaduse_rnone: got %b want %b", outs, c_NONE);
        end
        next_cycle();
        E_is_load_i = 1; E_dstM_i = 9; d_srcA_i = 9; d_srcB_i = 1;
        #2;
        n_cmp++;
        if (outs !== c_LOADUSE) begin
            n_fail++; $display("FAIL loaduse_srcA: got %b want %b", outs, c_LOADUSE);
        end
        next_cycle();
        E_is_load_i = 0;
        #2;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL loaduse_not_load: got %b want %b", outs, c_NONE);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_mdu();
        logic [9:0] exp_seq [5];
        exp_seq = '{c_MDU_ENT, c_MDU_WAIT, c_MDU_WAIT, c_MDU_DONE, c_NONE};
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            clear_inputs();
            if (i == 0) E_mdu_i = 1;
            // In the middle of the wait, all lower-priority events are ignored.
            if (i == 2) begin
                E_mdu_i = 1; e_mispred_i = 1;
                E_is_load_i = 1; E_dstM_i = 4; d_srcA_i = 4;
            end
            #2;
            n_cmp++;
            if (outs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL mdu_cycle%0d: got %b want %b", i + 1, outs, exp_seq[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        next_cycle();
        e_mispred_i = 1; E_is_load_i = 1; E_dstM_i = 7; d_srcB_i = 7;
        #2;
        n_cmp++;
        if (outs !== c_MISPRED) begin
            n_fail++; $display("FAIL prio_mispred_loaduse: got %b want %b", outs, c_MISPRED);
        end
        next_cycle();
        clear_inputs();
        e_mispred_i = 1; E_mdu_i = 1;
        #2;
        n_cmp++;
        if (outs !== c_MISPRED) begin
            n_fail++; $display("FAIL prio_mispred_mdu: got %b want %b", outs, c_MISPRED);
        end
        next_cycle();
        clear_inputs();
        #2;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL prio_no_mdu_entry: got %b want %b", outs, c_NONE);
        end
    endtask

    task automatic test_mdu_err();
        next_cycle();
        E_mdu_i = 1;
        next_cycle();
        clear_inputs();
        m_err_i = 1;
        #2;
        n_cmp++;
        if (outs !== c_MDU_WAIT) begin
            n_fail++; $display("FAIL mdu_err_cycle2: got %b want %b", outs, c_MDU_WAIT);
        end
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            clear_inputs();
            #2;
            n_cmp++;
            if (outs !== c_HALT) begin
                n_fail++;
                $display("FAIL mdu_err_halt%0d: got %b want %b", i, outs, c_HALT);
            end
        end
        pulse_reset("halt_mdu");
        next_cycle();
        #2;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL halt_mdu_release: got %b want %b", outs, c_NONE);
        end
    endtask

    task automatic test_run_halt();
        next_cycle();
        m_err_i = 1; e_mispred_i = 1;
        #2;
        n_cmp++;
        if (outs !== c_RUN_ERR) begin
            n_fail++; $display("FAIL run_err: got %b want %b", outs, c_RUN_ERR);
        end
        pulse_reset("run_err");
        next_cycle();
        W_halt_i = 1; E_mdu_i = 1;
        #2;
        n_cmp++;
        if (outs !== c_RUN_HALT) begin
            n_fail++; $display("FAIL run_halt: got %b want %b", outs, c_RUN_HALT);
        end
        next_cycle();
        clear_inputs();
        #2;
        n_cmp++;
        if (outs !== c_HALT) begin
            n_fail++; $display("FAIL run_halt_sticky: got %b want %b", outs, c_HALT);
        end
        pulse_reset("in_halt");
        next_cycle();
        #2;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL in_halt_release: got %b want %b", outs, c_NONE);
        end
    endtask

    task automatic test_async_mid_mdu();
        next_cycle();
        E_mdu_i = 1;
        next_cycle();
        clear_inputs();
        #2;
        n_cmp++;
        if (outs !== c_MDU_WAIT) begin
            n_fail++; $display("FAIL mid_mdu_wait: got %b want %b", outs, c_MDU_WAIT);
        end
        pulse_reset("mid_mdu");
        next_cycle();
        #2;
        n_cmp++;
        if (outs !== c_NONE) begin
            n_fail++; $display("FAIL mid_mdu_release: got %b want %b", outs, c_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mdu();
        test_priority();
        test_mdu_err();
        test_run_halt();
        test_async_mid_mdu();
        test_mdu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
